mem_responder: RTL

- Memory-side responder for the datapath's memory interface. It sits at the far end of the MAR and MDR outputs.
- It accepts one read or write request at a time, inserts a programmable number of wait states, and performs the access on an internal word-addressed RAM.
- It returns read data plus a one-cycle completion strobe. The datapath's MDR loads the read data and its control sequencer advances on that strobe.

---
 rtl/mem_responder.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Single-port memory responder: one request at a time, LATENCY wait states, then one RAM access.
// Optional address range check is compiled in with MEM_RANGE_CHECK_EN.
module mem_responder #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       mar_addr,
  input  logic [DATA_W-1:0] mdr_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [3:0] WaitLoad = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              op_rd_q, op_wr_q, bad_q;
  logic              accept, range_bad, bad_req;

  logic [DATA_W-1:0] mem [Depth];

`ifdef MEM_RANGE_CHECK_EN
  assign range_bad = |mar_addr[31:ADDR_W];
`else
  // High address bits alias; kept only to document that they are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mar_addr[31:ADDR_W];
  assign range_bad      = 1'b0;
`endif

  assign accept  = (state_q == StIdle) && (read || write);
  assign bad_req = (read && write) || range_bad;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (read || write) begin
          if (LATENCY == 0) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_rd_q <= 1'b0;
      op_wr_q <= 1'b0;
      bad_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= mar_addr[ADDR_W-1:0];
        wdata_q <= mdr_wdata;
        op_rd_q <= read && !write;
        op_wr_q <= write && !read;
        bad_q   <= bad_req;
      end
      // An out-of-range read returns zero rather than aliased data.
      if (state_q == StAccess && op_rd_q) begin
        rdata_q <= bad_q ? '0 : mem[addr_q];
      end
    end
  end

  // RAM is not reset; a reset before ACCESS leaves state_q idle so no write commits.
  always_ff @(posedge clk) begin
    if (state_q == StAccess && op_wr_q && !bad_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_busy  = (state_q != StIdle);
  assign mem_done  = (state_q == StDone);
  assign mem_err   = (state_q == StDone) && bad_q;

endmodule
